// File: rtl/neogeo_bus_pkg.sv
// ============================================================================
//  neogeo_bus_pkg
//  Shared types and constants for the 68000 bus responder.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package neogeo_bus_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        HOLD  = 3'd2,
        ACK   = 3'd3,
        IACK  = 3'd4,
        DRAIN = 3'd5
    } bus_state_e;

    localparam logic [19:0] IACK_ADDR_MASK = 20'hFFFFF;

    localparam logic [2:0] IRQ_LVL_NONE = 3'd0;
    localparam logic [2:0] IRQ_LVL_MAX  = 3'd3;

    function automatic logic [2:0] irq_highest(input logic [2:0] pend);
        if (pend[2])      return 3'd3;
        else if (pend[1]) return 3'd2;
        else if (pend[0]) return 3'd1;
        else              return IRQ_LVL_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/m68k_bus_responder_irq_encoder.sv
// ============================================================================
//  irq_encoder
//  Rising-edge interrupt latch with priority encode and clear-by-level.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module irq_encoder
    import neogeo_bus_pkg::*;
(
    input  logic       CLK_24M,
    input  logic       nRESET,
    input  logic [2:0] irq_i,
    input  logic       clr_en_i,
    input  logic [2:0] clr_level_i,
    output logic [2:0] ipl_o
);

    logic [2:0] irq_prev_q;
    logic [2:0] pending_q, pending_d;
    logic [2:0] ipl_q, ipl_d;
    logic [2:0] clr_vec;

    always_comb begin
        clr_vec = 3'b000;
        if (clr_en_i && (clr_level_i != IRQ_LVL_NONE) && (clr_level_i <= IRQ_LVL_MAX))
            clr_vec = 3'b001 << (clr_level_i - 3'd1);
        // A new edge in the same cycle as its clear must not be lost.
        pending_d = (pending_q & ~clr_vec) | (irq_i & ~irq_prev_q);
        ipl_d     = ~irq_highest(pending_q);
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            irq_prev_q <= 3'b000;
            pending_q  <= 3'b000;
            ipl_q      <= 3'b111;
        end else begin
            irq_prev_q <= irq_i;
            pending_q  <= pending_d;
            ipl_q      <= ipl_d;
        end
    end

    assign ipl_o = ipl_q;

endmodule

`default_nettype wire

// File: rtl/m68k_bus_responder.sv
// ============================================================================
//  m68k_bus_responder
//  Converts FX68K bus cycles into req/ack fabric transactions, drives
//  nDTACK/nVPA and the encoded IPL lines.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module m68k_bus_responder
    import neogeo_bus_pkg::*;
#(
    parameter int unsigned WAIT_MIN = 2
) (
    input  logic        CLK_24M,
    input  logic        nRESET,
    input  logic        M68K_CLKEN,
    input  logic [22:0] M68K_ADDR,
    input  logic [15:0] FX68K_DATAOUT,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        M68K_RW,
    output logic        nDTACK,
    output logic        nVPA,
    output logic [15:0] BUS_DATA,
    output logic        IPL2,
    output logic        IPL1,
    output logic        IPL0,
    input  logic [2:0]  IRQ_IN,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [22:0] MEM_ADDR,
    output logic [1:0]  MEM_BE,
    output logic [15:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [15:0] MEM_RDATA
);

    localparam logic [7:0] WAIT_MIN_C = 8'(WAIT_MIN);

    bus_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dtack_n_q, dtack_n_d;
    logic        vpa_n_q, vpa_n_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [22:0] addr_q, addr_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        clr_en;
    logic [2:0]  ipl;

    logic start_seen, as_high, is_iack;
    assign start_seen = M68K_CLKEN && !nAS && (!nUDS || !nLDS);
    assign as_high    = M68K_CLKEN && nAS;
    assign is_iack    = ((M68K_ADDR[22:3] & IACK_ADDR_MASK) == IACK_ADDR_MASK);

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        dtack_n_d = dtack_n_q;
        vpa_n_d   = vpa_n_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        clr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_seen) begin
                    // Count from 1 so the compare below yields exactly WAIT_MIN cycles.
                    cnt_d = 8'd1;
                    if (is_iack) begin
                        vpa_n_d = 1'b0;
                        clr_en  = 1'b1;
                        state_d = IACK;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = !M68K_RW;
                        addr_d  = M68K_ADDR;
                        be_d    = {!nUDS, !nLDS};
                        wdata_d = FX68K_DATAOUT;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (MEM_ACK) begin
                    req_d = 1'b0;
                    if (!we_q) rdata_d = MEM_RDATA;
                    state_d = HOLD;
                end else if (as_high) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (MEM_ACK) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (as_high) begin
                    state_d = IDLE;
                end else if (cnt_q >= WAIT_MIN_C) begin
                    dtack_n_d = 1'b0;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (as_high) begin
                    dtack_n_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            IACK: begin
                if (as_high) begin
                    vpa_n_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            dtack_n_q <= 1'b1;
            vpa_n_q   <= 1'b1;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 23'd0;
            be_q      <= 2'b00;
            wdata_q   <= 16'd0;
            rdata_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dtack_n_q <= dtack_n_d;
            vpa_n_q   <= vpa_n_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    irq_encoder u_irq_encoder (
        .CLK_24M     (CLK_24M),
        .nRESET      (nRESET),
        .irq_i       (IRQ_IN),
        .clr_en_i    (clr_en),
        .clr_level_i (M68K_ADDR[2:0]),
        .ipl_o       (ipl)
    );

    assign nDTACK    = dtack_n_q;
    assign nVPA      = vpa_n_q;
    assign BUS_DATA  = rdata_q;
    assign MEM_REQ   = req_q;
    assign MEM_WE    = we_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_BE    = be_q;
    assign MEM_WDATA = wdata_q;
    assign IPL2      = ipl[2];
    assign IPL1      = ipl[1];
    assign IPL0      = ipl[0];

endmodule

`default_nettype wire

// File: tb/tb_m68k_bus_responder.sv
// ============================================================================
//  tb_m68k_bus_responder
//  Directed self-checking bench with a transaction scoreboard.
//  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_m68k_bus_responder;

    logic        CLK_24M = 1'b0;
    logic        nRESET;
    logic        M68K_CLKEN;
    logic [22:0] M68K_ADDR;
    logic [15:0] FX68K_DATAOUT;
    logic        nAS, nUDS, nLDS, M68K_RW;
    logic        nDTACK, nVPA;
    logic [15:0] BUS_DATA;
    logic        IPL2, IPL1, IPL0;
    logic [2:0]  IRQ_IN;
    logic        MEM_REQ, MEM_WE;
    logic [22:0] MEM_ADDR;
    logic [1:0]  MEM_BE;
    logic [15:0] MEM_WDATA;
    logic        MEM_ACK;
    logic [15:0] MEM_RDATA;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [22:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } txn_t;

    txn_t sb[$];

    m68k_bus_responder #(.WAIT_MIN(2)) dut (
        .CLK_24M       (CLK_24M),
        .nRESET        (nRESET),
        .M68K_CLKEN    (M68K_CLKEN),
        .M68K_ADDR     (M68K_ADDR),
        .FX68K_DATAOUT (FX68K_DATAOUT),
        .nAS           (nAS),
        .nUDS          (nUDS),
        .nLDS          (nLDS),
        .M68K_RW       (M68K_RW),
        .nDTACK        (nDTACK),
        .nVPA          (nVPA),
        .BUS_DATA      (BUS_DATA),
        .IPL2          (IPL2),
        .IPL1          (IPL1),
        .IPL0          (IPL0),
        .IRQ_IN        (IRQ_IN),
        .MEM_REQ       (MEM_REQ),
        .MEM_WE        (MEM_WE),
        .MEM_ADDR      (MEM_ADDR),
        .MEM_BE        (MEM_BE),
        .MEM_WDATA     (MEM_WDATA),
        .MEM_ACK       (MEM_ACK),
        .MEM_RDATA     (MEM_RDATA)
    );

    always #20 CLK_24M = ~CLK_24M;

    task automatic tick();
        @(posedge CLK_24M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dtack"}, nDTACK, 1'b1);
        check({tag, "_vpa"},   nVPA, 1'b1);
        check({tag, "_ipl"},   {IPL2, IPL1, IPL0}, 3'b111);
        check({tag, "_req"},   MEM_REQ, 1'b0);
        check({tag, "_we"},    MEM_WE, 1'b0);
        check({tag, "_addr"},  MEM_ADDR, 23'd0);
        check({tag, "_be"},    MEM_BE, 2'b00);
        check({tag, "_wdata"}, MEM_WDATA, 16'd0);
        check({tag, "_rdata"}, BUS_DATA, 16'd0);
    endtask

    // Drive a CPU cycle start; data cycles also queue the expected fabric request.
    task automatic cpu_start(input logic [22:0] a, input logic rw, input logic uds,
                             input logic lds, input logic [15:0] wd, input logic push);
        M68K_ADDR     = a;
        M68K_RW       = rw;
        FX68K_DATAOUT = wd;
        nAS           = 1'b0;
        nUDS          = uds;
        nLDS          = lds;
        if (push) sb.push_back('{we: ~rw, addr: a, be: {~uds, ~lds}, wdata: wd});
    endtask

    task automatic cpu_end();
        nAS  = 1'b1;
        nUDS = 1'b1;
        nLDS = 1'b1;
    endtask

    // Wait (bounded) for a fabric request and score it against the queue head.
    task automatic fabric_expect(input string tag);
        txn_t e;
        int   n = 0;
        while (!MEM_REQ && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_req_seen"}, MEM_REQ, 1'b1);
        check({tag, "_sb_nonempty"}, (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_we"},   MEM_WE, e.we);
            check({tag, "_addr"}, MEM_ADDR, e.addr);
            check({tag, "_be"},   MEM_BE, e.be);
            if (e.we) check({tag, "_wdata"}, MEM_WDATA, e.wdata);
        end
    endtask

    task automatic mem_ack(input logic [15:0] rd);
        MEM_ACK   = 1'b1;
        MEM_RDATA = rd;
        tick();
        MEM_ACK   = 1'b0;
    endtask

    initial begin
        nRESET = 1'b0; M68K_CLKEN = 1'b1; M68K_ADDR = '0; FX68K_DATAOUT = '0;
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; M68K_RW = 1'b1;
        IRQ_IN = 3'b000; MEM_ACK = 1'b0; MEM_RDATA = '0;

        repeat (3) tick();
        check_reset_outputs("rst");
        nRESET = 1'b1;
        tick();

        // Read, MEM_ACK three cycles after the request
        cpu_start(23'h000080, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        fabric_expect("rd");
        tick(); tick();
        mem_ack(16'hBEEF);
        check("rd_req_drop", MEM_REQ, 1'b0);
        check("rd_data", BUS_DATA, 16'hBEEF);
        check("rd_dtack_hold", nDTACK, 1'b1);
        tick();
        check("rd_dtack_low", nDTACK, 1'b0);
        check("rd_vpa_high", nVPA, 1'b1);
        repeat (3) tick();
        check("rd_dtack_kept", nDTACK, 1'b0);
        cpu_end();
        tick();
        check("rd_dtack_release", nDTACK, 1'b1);

        // Byte write on the low lane with an immediate MEM_ACK
        cpu_start(23'h1E0006, 1'b0, 1'b1, 1'b0, 16'h00A5, 1'b1);
        fabric_expect("wr");
        mem_ack(16'h1234);
        check("wr_req_drop", MEM_REQ, 1'b0);
        check("wr_dtack_early", nDTACK, 1'b1);
        check("wr_no_capture", BUS_DATA, 16'hBEEF);
        tick();
        check("wr_dtack_min", nDTACK, 1'b0);
        cpu_end();
        tick();
        check("wr_dtack_release", nDTACK, 1'b1);
        repeat (4) tick();
        check("wr_single_req", MEM_REQ, 1'b0);

        // Strobes seen with the CPU enable low must not start a cycle
        M68K_CLKEN = 1'b0;
        cpu_start(23'h000010, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (3) tick();
        check("clken_gate", MEM_REQ, 1'b0);
        cpu_end();
        M68K_CLKEN = 1'b1;
        tick();

        // Interrupts: levels 1 and 2 raised, then acknowledged
        IRQ_IN = 3'b011;
        tick();
        check("irq_latency", {IPL2, IPL1, IPL0}, 3'b111);
        tick();
        check("irq_lvl2", {IPL2, IPL1, IPL0}, 3'b101);
        cpu_start({20'hFFFFF, 3'd2}, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        tick();
        check("iack2_vpa", nVPA, 1'b0);
        check("iack2_dtack", nDTACK, 1'b1);
        check("iack2_noreq", MEM_REQ, 1'b0);
        tick();
        check("iack2_ipl", {IPL2, IPL1, IPL0}, 3'b110);
        cpu_end();
        tick();
        check("iack2_vpa_release", nVPA, 1'b1);
        cpu_start({20'hFFFFF, 3'd1}, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        tick(); tick();
        check("iack1_ipl", {IPL2, IPL1, IPL0}, 3'b111);
        cpu_end();
        tick();

        // New level-1 edge in the same cycle as its acknowledge: the edge survives
        IRQ_IN = 3'b000;
        tick();
        cpu_start({20'hFFFFF, 3'd1}, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        IRQ_IN = 3'b001;
        tick();
        check("race_vpa", nVPA, 1'b0);
        tick();
        check("race_ipl", {IPL2, IPL1, IPL0}, 3'b110);
        cpu_end();
        tick();

        // Out-of-range level still autovectors and clears nothing
        cpu_start({20'hFFFFF, 3'd5}, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        tick();
        check("iack5_vpa", nVPA, 1'b0);
        tick();
        check("iack5_ipl", {IPL2, IPL1, IPL0}, 3'b110);
        cpu_end();
        tick();
        IRQ_IN = 3'b000;

        // Aborted read: request held until the late ack, no DTACK, read data untouched
        cpu_start(23'h000200, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        fabric_expect("abort");
        cpu_end();
        repeat (5) tick();
        check("abort_req_held", MEM_REQ, 1'b1);
        check("abort_dtack", nDTACK, 1'b1);
        mem_ack(16'hDEAD);
        check("abort_req_drop", MEM_REQ, 1'b0);
        repeat (3) tick();
        check("abort_dtack_after", nDTACK, 1'b1);
        check("abort_no_capture", BUS_DATA, 16'hBEEF);

        // Reset in HOLD, then a clean read
        cpu_start(23'h000040, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        fabric_expect("pre_rst");
        mem_ack(16'h5A5A);
        nRESET = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cpu_end();
        tick(); tick();
        nRESET = 1'b1;
        tick();
        cpu_start(23'h000055, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        fabric_expect("post_rst");
        mem_ack(16'h1357);
        check("post_rst_data", BUS_DATA, 16'h1357);
        tick();
        check("post_rst_dtack", nDTACK, 1'b0);
        cpu_end();
        tick();
        check("post_rst_release", nDTACK, 1'b1);

        check("sb_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
